// File: rtl/pc_fetch_unit_pkg.sv
// Shared bus widths, reset vector default and fetch FSM state encodings
// for the PC / instruction-fetch slice.
package pc_fetch_unit_pkg;

  localparam int ADDRESS_BUS_WIDTH    = 16;
  localparam int DATA_BUS_WIDTH       = 16;
  localparam int RESET_VECTOR_DEFAULT = 0;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_ISSUE = 2'd1
  } state_t;

endpackage

// File: rtl/pc_fetch_unit_pc_register.sv
// Program counter flop: async reset to RESET_VECTOR, loads i_load_val when i_load.
// Single-cycle update; no backpressure (caller decides when to load).
module pc_fetch_unit_pc_register #(
  parameter int                ADDR_W       = 16,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_val,
  output logic [ADDR_W-1:0] o_pc
);

  logic [ADDR_W-1:0] r_pc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc <= RESET_VECTOR;
    end else if (i_load) begin
      r_pc <= i_load_val;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/pc_fetch_unit.sv
// PC owner and fetch sequencer: one outstanding request, instr_valid one edge after ack.
// Stall drops fetch_req and freezes PC; issued instruction held until instr_ready (drain allowed under stall).
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W       = ADDRESS_BUS_WIDTH,
  parameter int                DATA_W       = DATA_BUS_WIDTH,
  parameter int                PC_INC       = 1,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(RESET_VECTOR_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              fetch_req,
  input  logic              fetch_ack,
  input  logic [DATA_W-1:0] instr_in,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_next_seq,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready
);

  state_t            r_state;
  logic [DATA_W-1:0] r_instr_out;
  logic [ADDR_W-1:0] r_instr_pc;
  logic              r_instr_valid;

  logic [ADDR_W-1:0] w_pc;
  logic [ADDR_W-1:0] w_pc_next_seq;
  logic [ADDR_W-1:0] w_pc_load_val;
  logic              w_pc_load;
  logic              w_fetch_req;
  logic              w_fire;

  // Gated by reset_n so the request vanishes the instant reset asserts.
  assign w_fetch_req   = reset_n & (r_state == S_FETCH) & ~stall & ~branch_valid;
  assign w_fire        = w_fetch_req & fetch_ack;
  assign w_pc_next_seq = w_pc + ADDR_W'(PC_INC);
  assign w_pc_load     = branch_valid | w_fire;
  assign w_pc_load_val = branch_valid ? branch_target : w_pc_next_seq;

  pc_fetch_unit_pc_register #(
    .ADDR_W      (ADDR_W),
    .RESET_VECTOR(RESET_VECTOR)
  ) u_pc_register (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_load    (w_pc_load),
    .i_load_val(w_pc_load_val),
    .o_pc      (w_pc)
  );

  // Branch wins over everything: any captured or in-flight instruction is dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_FETCH;
      r_instr_out   <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
    end else if (branch_valid) begin
      r_state       <= S_FETCH;
      r_instr_valid <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_fire) begin
            r_instr_out   <= instr_in;
            r_instr_pc    <= w_pc;
            r_instr_valid <= 1'b1;
            r_state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (instr_ready) begin
            r_instr_valid <= 1'b0;
            r_state       <= S_FETCH;
          end
        end
        default: begin
          r_instr_valid <= 1'b0;
          r_state       <= S_FETCH;
        end
      endcase
    end
  end

  assign fetch_req   = w_fetch_req;
  assign pc_out      = w_pc;
  assign pc_next_seq = w_pc_next_seq;
  assign instr_out   = r_instr_out;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_instr_valid;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: issued fetches push expected {instr, pc} into a
// scoreboard queue that a negedge monitor drains on every accepted instruction.
module tb_pc_fetch_unit;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic        branch_valid;
  logic [15:0] branch_target;
  logic        fetch_req;
  logic        fetch_ack;
  logic [15:0] instr_in;
  logic [15:0] pc_out;
  logic [15:0] pc_next_seq;
  logic [15:0] instr_out;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  pc_fetch_unit #(
    .ADDR_W      (16),
    .DATA_W      (16),
    .PC_INC      (1),
    .RESET_VECTOR(16'h0000)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .stall        (stall),
    .branch_valid (branch_valid),
    .branch_target(branch_target),
    .fetch_req    (fetch_req),
    .fetch_ack    (fetch_ack),
    .instr_in     (instr_in),
    .pc_out       (pc_out),
    .pc_next_seq  (pc_next_seq),
    .instr_out    (instr_out),
    .instr_pc     (instr_pc),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted instruction must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && instr_valid && instr_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected: got instr=%h pc=%h want none", instr_out, instr_pc);
        end else begin
          e = q.pop_front();
          chk("sb_instr", {16'h0, instr_out}, {16'h0, e.instr});
          chk("sb_pc", {16'h0, instr_pc}, {16'h0, e.pc});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n       = 1'b0;
    stall         = 1'b0;
    branch_valid  = 1'b0;
    branch_target = 16'h0;
    fetch_ack     = 1'b0;
    instr_in      = 16'h0;
    instr_ready   = 1'b0;

    #3;
    chk("rst_pc", pc_out, 16'h0000);
    chk("rst_req", fetch_req, 1'b0);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_instr", instr_out, 16'h0000);
    chk("rst_ipc", instr_pc, 16'h0000);

    // 1: single fetch, ack one cycle after request
    @(negedge clk);
    reset_n = 1'b1;
    cyc();
    fetch_ack = 1'b1;
    instr_in  = 16'hA5A5;
    q.push_back('{instr: 16'hA5A5, pc: 16'h0000});
    @(negedge clk);
    chk("t1_req", fetch_req, 1'b1);
    chk("t1_pc_pre", pc_out, 16'h0000);
    cyc();
    fetch_ack   = 1'b0;
    instr_ready = 1'b1;
    @(negedge clk);
    chk("t1_valid", instr_valid, 1'b1);
    chk("t1_pc", pc_out, 16'h0001);
    chk("t1_req_issue", fetch_req, 1'b0);
    cyc();
    instr_ready = 1'b0;
    @(negedge clk);
    chk("t1_valid_drop", instr_valid, 1'b0);
    chk("t1_req_again", fetch_req, 1'b1);

    // 2: ack delayed, request held for four cycles, PC unchanged until the ack edge
    for (int i = 0; i < 2; i++) begin
      cyc();
      @(negedge clk);
      chk("t2_req_wait", fetch_req, 1'b1);
      chk("t2_pc_wait", pc_out, 16'h0001);
    end
    cyc();
    fetch_ack = 1'b1;
    instr_in  = 16'h1234;
    q.push_back('{instr: 16'h1234, pc: 16'h0001});
    @(negedge clk);
    chk("t2_req_ack", fetch_req, 1'b1);
    chk("t2_pc_ack", pc_out, 16'h0001);
    cyc();
    fetch_ack = 1'b0;
    @(negedge clk);
    chk("t2_pc_post", pc_out, 16'h0002);
    chk("t2_valid", instr_valid, 1'b1);

    // 3: decode backpressure holds the instruction stable
    for (int i = 0; i < 5; i++) begin
      cyc();
      @(negedge clk);
      chk("t3_valid_hold", instr_valid, 1'b1);
      chk("t3_req_hold", fetch_req, 1'b0);
      chk("t3_instr_hold", instr_out, 16'h1234);
      chk("t3_ipc_hold", instr_pc, 16'h0001);
    end
    cyc();
    instr_ready = 1'b1;
    cyc();
    instr_ready = 1'b0;
    @(negedge clk);
    chk("t3_valid_drop", instr_valid, 1'b0);
    chk("t3_req", fetch_req, 1'b1);
    chk("t3_pc", pc_out, 16'h0002);

    // 4: branch in the same cycle as an ack discards the data
    cyc();
    branch_valid  = 1'b1;
    branch_target = 16'h0040;
    fetch_ack     = 1'b1;
    instr_in      = 16'hDEAD;
    @(negedge clk);
    chk("t4_req_br", fetch_req, 1'b0);
    cyc();
    branch_valid = 1'b0;
    fetch_ack    = 1'b0;
    @(negedge clk);
    chk("t4_pc", pc_out, 16'h0040);
    chk("t4_valid", instr_valid, 1'b0);
    chk("t4_req", fetch_req, 1'b1);
    chk("t4_seq", pc_next_seq, 16'h0041);

    // 5: all-ones PC wraps to zero
    cyc();
    branch_valid  = 1'b1;
    branch_target = 16'hFFFF;
    cyc();
    branch_valid = 1'b0;
    @(negedge clk);
    chk("t5_pc", pc_out, 16'hFFFF);
    chk("t5_seq_wrap", pc_next_seq, 16'h0000);
    cyc();
    fetch_ack = 1'b1;
    instr_in  = 16'hBEEF;
    q.push_back('{instr: 16'hBEEF, pc: 16'hFFFF});
    cyc();
    fetch_ack   = 1'b0;
    instr_ready = 1'b1;
    @(negedge clk);
    chk("t5_pc_wrap", pc_out, 16'h0000);
    chk("t5_valid", instr_valid, 1'b1);
    cyc();
    instr_ready = 1'b0;

    // 6: reset while an instruction is waiting, then stall with a stray ack
    cyc();
    branch_valid  = 1'b1;
    branch_target = 16'h0100;
    cyc();
    branch_valid = 1'b0;
    fetch_ack    = 1'b1;
    instr_in     = 16'h7777;
    cyc();
    fetch_ack = 1'b0;
    @(negedge clk);
    chk("t6_valid_pre", instr_valid, 1'b1);
    chk("t6_pc_pre", pc_out, 16'h0101);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_pc", pc_out, 16'h0000);
    chk("t6_rst_valid", instr_valid, 1'b0);
    chk("t6_rst_instr", instr_out, 16'h0000);
    chk("t6_rst_ipc", instr_pc, 16'h0000);
    chk("t6_rst_req", fetch_req, 1'b0);
    stall     = 1'b1;
    fetch_ack = 1'b1;
    instr_in  = 16'h5555;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      @(negedge clk);
      chk("t6_stall_req", fetch_req, 1'b0);
      chk("t6_stall_pc", pc_out, 16'h0000);
      chk("t6_stall_valid", instr_valid, 1'b0);
    end
    cyc();
    stall     = 1'b0;
    fetch_ack = 1'b0;
    @(negedge clk);
    chk("t6_req_resume", fetch_req, 1'b1);
    chk("t6_pc_resume", pc_out, 16'h0000);

    cyc();
    cyc();
    chk("sb_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
